// File: rtl/crossy_pkg.sv
// Shared types for the Crossy Roads player logic: move directions, sequencer states
// and the grid size that the renderer also uses.
package crossy_pkg;

    localparam int GRID_W_DEFAULT = 16;
    localparam int GRID_H_DEFAULT = 16;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

endpackage

// File: rtl/release_pulse.sv
// Release-edge detector for one already-synchronized button.
// The pulse is high for the cycle in which the button reads low after having been high.
module release_pulse (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    assign pulse = prev & ~btn;

endmodule

// File: rtl/player_move_sequencer.sv
// Converts four direction buttons into rate-limited, round-robin arbitrated player moves,
// keeps the clamped player position and the furthest-row progress score.
module player_move_sequencer
    import crossy_pkg::*;
#(
    parameter int GRID_W       = GRID_W_DEFAULT,
    parameter int GRID_H       = GRID_H_DEFAULT,
    parameter int START_X      = 7,
    parameter int START_Y      = 15,
    parameter int COOLDOWN_CYC = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      respawn,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    output logic [$clog2(GRID_W)-1:0] pos_x,
    output logic [$clog2(GRID_H)-1:0] pos_y,
    output logic                      move_valid,
    output dir_t                      move_dir,
    output logic                      blocked,
    output logic                      busy,
    output logic [7:0]                score
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = $clog2(COOLDOWN_CYC + 1);

    logic [3:0]    btn_vec;
    logic [3:0]    pulse;
    logic [3:0]    pending;
    logic [3:0]    req;
    logic [3:0]    grant_mask;
    logic [2:0]    pick;
    logic          grant_found;
    dir_t          grant_dir;
    dir_t          rr_ptr;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [YW-1:0] best_y;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          hit_edge;

    // Returns {found, dir}: first requesting direction at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input dir_t ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (r[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] s);
        return (s == 8'hFF) ? s : s + 8'd1;
    endfunction

    assign btn_vec = {btn_right, btn_left, btn_down, btn_up};

    for (genvar d = 0; d < 4; d++) begin : g_edge
        release_pulse u_release (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_vec[d]),
            .pulse (pulse[d])
        );
    end

    assign req         = en ? (pending | pulse) : 4'b0000;
    assign pick        = rr_pick(req, rr_ptr);
    assign grant_found = pick[2];
    assign grant_dir   = dir_t'(pick[1:0]);
    assign grant_mask  = 4'b0001 << pick[1:0];
    assign busy        = (state == COOLDOWN);

    // Target square for the candidate grant; an off-grid target leaves the position alone.
    always_comb begin
        next_x   = pos_x;
        next_y   = pos_y;
        hit_edge = 1'b0;
        case (grant_dir)
            DIR_UP: begin
                if (pos_y == '0) hit_edge = 1'b1;
                else             next_y   = pos_y - YW'(1);
            end
            DIR_DOWN: begin
                if (pos_y == YW'(GRID_H - 1)) hit_edge = 1'b1;
                else                          next_y   = pos_y + YW'(1);
            end
            DIR_LEFT: begin
                if (pos_x == '0) hit_edge = 1'b1;
                else             next_x   = pos_x - XW'(1);
            end
            DIR_RIGHT: begin
                if (pos_x == XW'(GRID_W - 1)) hit_edge = 1'b1;
                else                          next_x   = pos_x + XW'(1);
            end
            default: hit_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x      <= XW'(START_X);
            pos_y      <= YW'(START_Y);
            best_y     <= YW'(START_Y);
            score      <= 8'd0;
            move_valid <= 1'b0;
            blocked    <= 1'b0;
            move_dir   <= DIR_UP;
            pending    <= 4'b0000;
            rr_ptr     <= DIR_UP;
            state      <= IDLE;
            cnt        <= '0;
        end else begin
            move_valid <= 1'b0;
            blocked    <= 1'b0;
            if (respawn) begin
                // Any grant that would have happened this cycle is dropped.
                pos_x   <= XW'(START_X);
                pos_y   <= YW'(START_Y);
                best_y  <= YW'(START_Y);
                pending <= 4'b0000;
                state   <= IDLE;
            end else if (!en) begin
                pending <= 4'b0000;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_found) begin
                            move_valid <= 1'b1;
                            move_dir   <= grant_dir;
                            blocked    <= hit_edge;
                            pos_x      <= next_x;
                            pos_y      <= next_y;
                            if (grant_dir == DIR_UP && !hit_edge && next_y < best_y) begin
                                best_y <= next_y;
                                score  <= sat_inc(score);
                            end
                            pending <= req & ~grant_mask;
                            rr_ptr  <= dir_t'(pick[1:0] + 2'd1);
                            cnt     <= CW'(COOLDOWN_CYC);
                            state   <= COOLDOWN;
                        end else begin
                            pending <= req;
                        end
                    end
                    COOLDOWN: begin
                        pending <= req;
                        cnt     <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_move_sequencer.sv
// Bench for player_move_sequencer: directed vector table, multi-cycle corner sequences,
// then randomized stimulus against a cycle-level behavioural model.
module tb_player_move_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       respawn = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       blocked;
    logic       busy;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_move_sequencer #(
        .GRID_W(16), .GRID_H(16), .START_X(7), .START_Y(15), .COOLDOWN_CYC(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .respawn    (respawn),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_left   (btn[2]),
        .btn_right  (btn[3]),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .blocked    (blocked),
        .busy       (busy),
        .score      (score)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural reference: integers for position, a remaining-cooldown count, a pending bit per direction.
    int       m_x = 7, m_y = 15, m_best = 15, m_score = 0, m_cool = 0, m_ptr = 0, m_dir = 0;
    bit [3:0] m_prev = 0, m_pend = 0;
    bit       m_mv = 0, m_blk = 0;

    always @(posedge clk) begin
        bit [3:0] pls, req;
        int g, d, tx, ty;
        pls = m_prev & ~btn;
        if (reset) begin
            m_x = 7; m_y = 15; m_best = 15; m_score = 0; m_cool = 0; m_ptr = 0; m_dir = 0;
            m_pend = 0; m_mv = 0; m_blk = 0; m_prev = 0;
        end else begin
            m_prev = btn;
            m_mv = 0;
            m_blk = 0;
            if (respawn) begin
                m_x = 7; m_y = 15; m_best = 15; m_pend = 0; m_cool = 0;
            end else if (!en) begin
                m_pend = 0; m_cool = 0;
            end else begin
                req = m_pend | pls;
                g = -1;
                for (int k = 0; k < 4; k++) begin
                    d = (m_ptr + k) % 4;
                    if (g < 0 && req[d]) g = d;
                end
                if (m_cool == 0 && g >= 0) begin
                    tx = m_x; ty = m_y;
                    case (g)
                        0: ty = m_y - 1;
                        1: ty = m_y + 1;
                        2: tx = m_x - 1;
                        default: tx = m_x + 1;
                    endcase
                    m_mv = 1;
                    m_dir = g;
                    if (tx < 0 || tx > 15 || ty < 0 || ty > 15) begin
                        m_blk = 1;
                    end else begin
                        m_x = tx; m_y = ty;
                        if (g == 0 && ty < m_best) begin
                            m_best = ty;
                            if (m_score < 255) m_score++;
                        end
                    end
                    req[g] = 1'b0;
                    m_pend = req;
                    m_ptr = (g + 1) % 4;
                    m_cool = 4;
                end else begin
                    m_pend = req;
                    if (m_cool > 0) m_cool--;
                end
            end
        end
    end

    typedef struct {
        logic [3:0] btn;
        logic       en;
        logic       rsp;
        logic       mv;
        int         dir;   // -1: not checked
        logic       blk;
        int         x;
        int         y;
        int         sc;
        logic       bsy;
    } vec_t;

    vec_t tbl[24];

    task automatic press(input int d, output bit seen);
        @(negedge clk);
        btn = 4'b0000;
        btn[d] = 1'b1;
        @(negedge clk);
        btn = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (move_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 10 && !idle; c++) begin
            @(posedge clk);
            #1;
            if (!busy) idle = 1'b1;
        end
        check(name, idle, 1);
    endtask

    initial begin
        bit seen;
        //                btn    en rsp mv dir blk x  y   sc bsy
        tbl[0]  = '{4'b0001, 1, 0, 0, -1, 0, 7, 15, 0, 0};
        tbl[1]  = '{4'b0001, 1, 0, 0, -1, 0, 7, 15, 0, 0};
        tbl[2]  = '{4'b0001, 1, 0, 0, -1, 0, 7, 15, 0, 0};
        tbl[3]  = '{4'b0000, 1, 0, 1,  0, 0, 7, 14, 1, 1};
        tbl[4]  = '{4'b0000, 1, 0, 0, -1, 0, 7, 14, 1, 1};
        tbl[5]  = '{4'b0000, 1, 0, 0, -1, 0, 7, 14, 1, 1};
        tbl[6]  = '{4'b0000, 1, 0, 0, -1, 0, 7, 14, 1, 1};
        tbl[7]  = '{4'b0000, 1, 0, 0, -1, 0, 7, 14, 1, 0};
        tbl[8]  = '{4'b1001, 1, 0, 0, -1, 0, 7, 14, 1, 0};
        tbl[9]  = '{4'b0000, 1, 0, 1,  3, 0, 8, 14, 1, 1};
        tbl[10] = '{4'b0000, 1, 0, 0, -1, 0, 8, 14, 1, 1};
        tbl[11] = '{4'b0000, 1, 0, 0, -1, 0, 8, 14, 1, 1};
        tbl[12] = '{4'b0000, 1, 0, 0, -1, 0, 8, 14, 1, 1};
        tbl[13] = '{4'b0000, 1, 0, 0, -1, 0, 8, 14, 1, 0};
        tbl[14] = '{4'b0000, 1, 0, 1,  0, 0, 8, 13, 2, 1};
        tbl[15] = '{4'b0000, 1, 0, 0, -1, 0, 8, 13, 2, 1};
        tbl[16] = '{4'b0000, 1, 0, 0, -1, 0, 8, 13, 2, 1};
        tbl[17] = '{4'b0000, 1, 0, 0, -1, 0, 8, 13, 2, 1};
        tbl[18] = '{4'b0000, 1, 0, 0, -1, 0, 8, 13, 2, 0};
        tbl[19] = '{4'b0100, 1, 0, 0, -1, 0, 8, 13, 2, 0};
        tbl[20] = '{4'b0000, 0, 0, 0, -1, 0, 8, 13, 2, 0};
        tbl[21] = '{4'b0100, 1, 0, 0, -1, 0, 8, 13, 2, 0};
        tbl[22] = '{4'b0000, 1, 1, 0, -1, 0, 7, 15, 2, 0};
        tbl[23] = '{4'b0000, 1, 0, 0, -1, 0, 7, 15, 2, 0};

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_x", pos_x, 7);
        check("reset_y", pos_y, 15);
        check("reset_score", score, 0);
        check("reset_busy", busy, 0);
        check("reset_mv", move_valid, 0);
        check("reset_blk", blocked, 0);
        check("reset_dir", move_dir, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            btn = tbl[i].btn;
            en = tbl[i].en;
            respawn = tbl[i].rsp;
            @(posedge clk);
            #1;
            check($sformatf("row%0d_mv", i), move_valid, tbl[i].mv);
            if (tbl[i].dir >= 0) check($sformatf("row%0d_dir", i), move_dir, tbl[i].dir);
            check($sformatf("row%0d_blk", i), blocked, tbl[i].blk);
            check($sformatf("row%0d_x", i), pos_x, tbl[i].x);
            check($sformatf("row%0d_y", i), pos_y, tbl[i].y);
            check($sformatf("row%0d_score", i), score, tbl[i].sc);
            check($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
        end

        // Walk left from x=7 into the edge; the eighth move is blocked but still granted.
        for (int i = 0; i < 8; i++) begin
            press(2, seen);
            check($sformatf("left%0d_seen", i), seen, 1);
            check($sformatf("left%0d_dir", i), move_dir, 2);
            check($sformatf("left%0d_x", i), pos_x, (i < 7) ? 6 - i : 0);
            check($sformatf("left%0d_blk", i), blocked, (i == 7) ? 1 : 0);
            wait_idle($sformatf("left%0d_idle", i));
        end

        // Revisiting a row that was already reached earns nothing.
        press(0, seen);
        check("up1_seen", seen, 1);
        check("up1_score", score, 3);
        wait_idle("up1_idle");
        press(1, seen);
        check("down_seen", seen, 1);
        check("down_y", pos_y, 15);
        wait_idle("down_idle");
        press(0, seen);
        check("up2_seen", seen, 1);
        check("up2_y", pos_y, 14);
        check("up2_score", score, 3);
        wait_idle("up2_idle");

        @(negedge clk);
        reset = 1'b1;
        btn = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 3) == 0) btn[d] = ~btn[d];
            end
            en = ($urandom_range(0, 15) != 0);
            respawn = ($urandom_range(0, 47) == 0);
            reset = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
            check("rand_mv", move_valid, m_mv);
            check("rand_blk", blocked, m_blk);
            check("rand_x", pos_x, m_x);
            check("rand_y", pos_y, m_y);
            check("rand_score", score, m_score);
            check("rand_busy", busy, (m_cool > 0) ? 1 : 0);
            if (m_mv) check("rand_dir", move_dir, m_dir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
